lif_neuron_array_core: RTL and testbench

//  Time-multiplexed array of leaky integrate-and-fire neurons with per-neuron state in register files.

---
 rtl/lif_neuron_array_core_pkg.sv | 18 +
 rtl/lif_neuron_array_core_sync_fifo.sv | 62 ++++++
 rtl/lif_neuron_array_core.sv | 204 ++++++++++++++++++++
 tb/tb_lif_neuron_array_core.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_neuron_array_core_pkg.sv
// Shared types and constants for the LIF neuron array: FSM states,
// queue depths and the bit layout of a per-neuron config word.
package lif_neuron_array_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_FIRE   = 2'd3
  } lif_state_t;

  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 16;

  localparam int CFG_V_LSB      = 0;
  localparam int CFG_REFRAC_LSB = 16;

endpackage

// File: rtl/lif_neuron_array_core_sync_fifo.sv
// Synchronous FIFO with show-ahead read data, used for the event and spike queues.
module sync_fifo
  import lif_neuron_array_core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = IN_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];

  // storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lif_neuron_array_core.sv
// Time-multiplexed leaky integrate-and-fire neuron array: integrates queued
// synaptic events, runs a background leak sweep and queues the ids of firing neurons.
module lif_neuron_array_core
  import lif_neuron_array_core_pkg::*;
#(
  parameter int NUM_NEURONS           = 64,
  parameter int NEURON_ID_WIDTH       = $clog2(NUM_NEURONS),
  parameter int NUM_AXONS             = 64,
  parameter int DATA_WIDTH            = 16,
  parameter int WEIGHT_WIDTH          = 8,
  parameter int THRESHOLD_WIDTH       = 16,
  parameter int LEAK_WIDTH            = 8,
  parameter int REFRAC_WIDTH          = 8,
  parameter int TIME_MULTIPLEX_FACTOR = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       s_axis_spike_valid,
  output logic                       s_axis_spike_ready,
  input  logic [NEURON_ID_WIDTH-1:0] s_axis_spike_dest_id,
  input  logic [WEIGHT_WIDTH-1:0]    s_axis_spike_weight,
  input  logic                       s_axis_spike_exc_inh,
  output logic                       m_axis_spike_valid,
  input  logic                       m_axis_spike_ready,
  output logic [NEURON_ID_WIDTH-1:0] m_axis_spike_neuron_id,
  input  logic                       config_we,
  input  logic [NEURON_ID_WIDTH-1:0] config_addr,
  input  logic [31:0]                config_data,
  input  logic [THRESHOLD_WIDTH-1:0] global_threshold,
  input  logic [LEAK_WIDTH-1:0]      global_leak_rate,
  input  logic [REFRAC_WIDTH-1:0]    global_refrac_period,
  output logic [31:0]                spike_count,
  output logic                       array_busy
);

  localparam int EV_W     = NEURON_ID_WIDTH + WEIGHT_WIDTH + 1;
  localparam int CMP_W    = (DATA_WIDTH > THRESHOLD_WIDTH) ? DATA_WIDTH : THRESHOLD_WIDTH;
  localparam int TICK_W   = (TIME_MULTIPLEX_FACTOR > 1) ? $clog2(TIME_MULTIPLEX_FACTOR) : 1;
  localparam int UNUSED_AXONS = NUM_AXONS;

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (b > a) ? {DATA_WIDTH{1'b0}} : a - b;
  endfunction

  logic [DATA_WIDTH-1:0]      v_mem_r      [NUM_NEURONS];
  logic [REFRAC_WIDTH-1:0]    refrac_mem_r [NUM_NEURONS];
  lif_state_t                 state_r;
  logic [NEURON_ID_WIDTH-1:0] cur_id_r;
  logic [WEIGHT_WIDTH-1:0]    cur_w_r;
  logic                       cur_exc_r;
  logic [DATA_WIDTH-1:0]      cur_v_r;
  logic [REFRAC_WIDTH-1:0]    cur_refrac_r;
  logic [TICK_W-1:0]          tick_cnt_r;
  logic                       leak_pending_r;
  logic [NEURON_ID_WIDTH-1:0] leak_ptr_r;

  logic                       in_push_s;
  logic                       in_full_s;
  logic                       in_empty_s;
  logic [EV_W-1:0]            in_data_s;
  logic                       out_push_s;
  logic                       out_pop_s;
  logic                       out_full_s;
  logic                       out_empty_s;
  logic                       ev_go_s;
  logic                       leak_go_s;
  logic                       tick_s;
  logic [DATA_WIDTH-1:0]      upd_v_s;
  logic                       fire_s;
  logic [DATA_WIDTH-1:0]      leak_v_s;
  logic [REFRAC_WIDTH-1:0]    leak_refrac_s;
  logic                       unused_cfg_bits;

  assign unused_cfg_bits    = ^config_data;
  assign s_axis_spike_ready = enable & ~in_full_s;
  assign in_push_s          = s_axis_spike_valid & s_axis_spike_ready;
  assign m_axis_spike_valid = ~out_empty_s;
  assign out_pop_s          = m_axis_spike_valid & m_axis_spike_ready;
  assign out_push_s         = (state_r == ST_FIRE) & ~out_full_s;
  assign array_busy         = ~in_empty_s | (state_r != ST_IDLE) | ~out_empty_s;

  sync_fifo #(.WIDTH(EV_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push_s),
    .push_data ({s_axis_spike_exc_inh, s_axis_spike_weight, s_axis_spike_dest_id}),
    .pop       (ev_go_s),
    .pop_data  (in_data_s),
    .full      (in_full_s),
    .empty     (in_empty_s)
  );

  sync_fifo #(.WIDTH(NEURON_ID_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push_s),
    .push_data (cur_id_r),
    .pop       (out_pop_s),
    .pop_data  (m_axis_spike_neuron_id),
    .full      (out_full_s),
    .empty     (out_empty_s)
  );

  // scheduling decisions and next-state arithmetic for event and leak updates
  always_comb begin
    ev_go_s   = (state_r == ST_IDLE) & enable & ~in_empty_s;
    leak_go_s = (state_r == ST_IDLE) & enable & in_empty_s & leak_pending_r;
    tick_s    = enable & (tick_cnt_r == TICK_W'(TIME_MULTIPLEX_FACTOR - 1));
    if (cur_exc_r) begin
      upd_v_s = sat_add(cur_v_r, DATA_WIDTH'(cur_w_r));
    end else begin
      upd_v_s = sat_sub(cur_v_r, DATA_WIDTH'(cur_w_r));
    end
    fire_s   = (CMP_W'(upd_v_s) >= CMP_W'(global_threshold));
    leak_v_s = sat_sub(v_mem_r[leak_ptr_r], DATA_WIDTH'(global_leak_rate));
    if (refrac_mem_r[leak_ptr_r] != {REFRAC_WIDTH{1'b0}}) begin
      leak_refrac_s = refrac_mem_r[leak_ptr_r] - REFRAC_WIDTH'(1);
    end else begin
      leak_refrac_s = {REFRAC_WIDTH{1'b0}};
    end
  end

  // control FSM, neuron state arrays, leak timer and spike counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cur_id_r       <= {NEURON_ID_WIDTH{1'b0}};
      cur_w_r        <= {WEIGHT_WIDTH{1'b0}};
      cur_exc_r      <= 1'b0;
      cur_v_r        <= {DATA_WIDTH{1'b0}};
      cur_refrac_r   <= {REFRAC_WIDTH{1'b0}};
      tick_cnt_r     <= {TICK_W{1'b0}};
      leak_pending_r <= 1'b0;
      leak_ptr_r     <= {NEURON_ID_WIDTH{1'b0}};
      spike_count    <= 32'd0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_mem_r[i]      <= {DATA_WIDTH{1'b0}};
        refrac_mem_r[i] <= {REFRAC_WIDTH{1'b0}};
      end
    end else begin
      if (tick_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else if (enable) begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
      // a tick arriving while a step is still pending collapses into it
      leak_pending_r <= tick_s | (leak_pending_r & ~leak_go_s);

      case (state_r)
        ST_IDLE: begin
          if (ev_go_s) begin
            {cur_exc_r, cur_w_r, cur_id_r} <= in_data_s;
            state_r <= ST_READ;
          end else if (leak_go_s) begin
            v_mem_r[leak_ptr_r]      <= leak_v_s;
            refrac_mem_r[leak_ptr_r] <= leak_refrac_s;
            leak_ptr_r <= (leak_ptr_r == NEURON_ID_WIDTH'(NUM_NEURONS - 1)) ?
                          {NEURON_ID_WIDTH{1'b0}} : leak_ptr_r + NEURON_ID_WIDTH'(1);
          end
        end
        ST_READ: begin
          cur_v_r      <= v_mem_r[cur_id_r];
          cur_refrac_r <= refrac_mem_r[cur_id_r];
          state_r      <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (cur_refrac_r != {REFRAC_WIDTH{1'b0}}) begin
            state_r <= ST_IDLE;
          end else if (fire_s) begin
            v_mem_r[cur_id_r]      <= {DATA_WIDTH{1'b0}};
            refrac_mem_r[cur_id_r] <= global_refrac_period;
            spike_count            <= spike_count + 32'd1;
            state_r                <= ST_FIRE;
          end else begin
            v_mem_r[cur_id_r] <= upd_v_s;
            state_r           <= ST_IDLE;
          end
        end
        ST_FIRE: begin
          if (!out_full_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      // host writes land last so they win over a same-cycle FSM update
      if (config_we) begin
        v_mem_r[config_addr]      <= config_data[CFG_V_LSB +: DATA_WIDTH];
        refrac_mem_r[config_addr] <= config_data[CFG_REFRAC_LSB +: REFRAC_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array_core.sv
// Directed self-checking bench for lif_neuron_array_core: threshold, refractory,
// saturation, leak, latency and back-pressure scenarios with hand-computed results.
module tb_lif_neuron_array_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [5:0]  s_dest;
  logic [7:0]  s_weight;
  logic        s_exc;
  logic        m_valid;
  logic        m_ready;
  logic [5:0]  m_id;
  logic        config_we;
  logic [5:0]  config_addr;
  logic [31:0] config_data;
  logic [15:0] thr;
  logic [7:0]  leak;
  logic [7:0]  refrac;
  logic [31:0] spike_count;
  logic        array_busy;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  logic [5:0] got_q[$];

  lif_neuron_array_core dut (
    .clk                    (clk),
    .rst                    (rst),
    .enable                 (enable),
    .s_axis_spike_valid     (s_valid),
    .s_axis_spike_ready     (s_ready),
    .s_axis_spike_dest_id   (s_dest),
    .s_axis_spike_weight    (s_weight),
    .s_axis_spike_exc_inh   (s_exc),
    .m_axis_spike_valid     (m_valid),
    .m_axis_spike_ready     (m_ready),
    .m_axis_spike_neuron_id (m_id),
    .config_we              (config_we),
    .config_addr            (config_addr),
    .config_data            (config_data),
    .global_threshold       (thr),
    .global_leak_rate       (leak),
    .global_refrac_period   (refrac),
    .spike_count            (spike_count),
    .array_busy             (array_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid && m_ready) got_q.push_back(m_id);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int a, input logic [31:0] d);
    config_we   = 1'b1;
    config_addr = a[5:0];
    config_data = d;
    @(posedge clk);
    #1;
    config_we = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) cfg(i, 32'd0);
  endtask

  task automatic send(input int id, input int w, input logic exc);
    int t;
    s_valid  = 1'b1;
    s_dest   = id[5:0];
    s_weight = w[7:0];
    s_exc    = exc;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ready=%0b required=1 for id=%0d", s_ready, id);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_dest = 6'd0; s_weight = 8'd0; s_exc = 1'b0;
    m_ready = 1'b0; config_we = 1'b0; config_addr = 6'd0; config_data = 32'd0;
    thr = 16'd1000; leak = 8'd0; refrac = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_disabled: got=%0b exp=0", s_ready); end
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got=%0b exp=0", m_valid); end
    checks++;
    if (spike_count !== 32'd0) begin failures++; $display("FAIL reset_spike_count: got=%0d exp=0", spike_count); end
    checks++;
    if (array_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%0b exp=0", array_busy); end
    enable = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_enabled: got=%0b exp=1", s_ready); end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_below_threshold();
    thr = 16'd1000;
    got_q.delete();
    send(0, 100, 1'b1);
    idle(50);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL below_thr_spikes: got=%0d exp=0", got_q.size()); end
    checks++;
    if (spike_count !== 32'(exp_count)) begin failures++; $display("FAIL below_thr_count: got=%0d exp=%0d", spike_count, exp_count); end
  endtask

  task automatic test_single_fire();
    thr = 16'd200;
    got_q.delete();
    send(1, 255, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL latency_m_valid: got=%0b exp=1", m_valid); end
    idle(10);
    exp_count += 1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 6'd1) begin
      failures++; $display("FAIL single_fire_id: n=%0d id=%0d exp n=1 id=1", got_q.size(), got_q[0]);
    end
    checks++;
    if (spike_count !== 32'(exp_count)) begin failures++; $display("FAIL single_fire_count: got=%0d exp=%0d", spike_count, exp_count); end
  endtask

  task automatic test_refractory();
    thr = 16'd500;
    refrac = 8'd10;
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      send(2, 150, 1'b1);
      idle(10);
      checks++;
      if (got_q.size() != ((i >= 3) ? 1 : 0)) begin
        failures++; $display("FAIL refrac_event%0d: spikes=%0d exp=%0d", i, got_q.size(), (i >= 3) ? 1 : 0);
      end
    end
    exp_count += 1;
    checks++;
    if (got_q[0] !== 6'd2 || spike_count !== 32'(exp_count)) begin
      failures++; $display("FAIL refrac_id_count: id=%0d cnt=%0d exp id=2 cnt=%0d", got_q[0], spike_count, exp_count);
    end
  endtask

  task automatic test_inhibit();
    thr = 16'd500;
    refrac = 8'd0;
    got_q.delete();
    send(3, 200, 1'b1);
    send(3, 150, 1'b0);
    idle(10);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL inh_no_spike: got=%0d exp=0", got_q.size()); end
    send(3, 100, 1'b0);
    send(3, 255, 1'b1);
    send(3, 244, 1'b1);
    idle(10);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL inh_floor_499: spikes=%0d exp=0", got_q.size()); end
    send(3, 1, 1'b1);
    idle(10);
    exp_count += 1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 6'd3) begin
      failures++; $display("FAIL inh_floor_500: n=%0d id=%0d exp n=1 id=3", got_q.size(), got_q[0]);
    end
  endtask

  task automatic test_saturate_and_config();
    thr = 16'd65535;
    got_q.delete();
    cfg(5, 32'd65500);
    send(5, 255, 1'b1);
    idle(10);
    exp_count += 1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 6'd5) begin
      failures++; $display("FAIL add_saturate: n=%0d id=%0d exp n=1 id=5", got_q.size(), got_q[0]);
    end
    thr = 16'd100;
    got_q.delete();
    cfg(6, 32'h0005_0000);
    send(6, 200, 1'b1);
    idle(10);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL cfg_refrac_discard: spikes=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_leak();
    thr = 16'd200;
    got_q.delete();
    cfg(7, 32'd150);
    leak = 8'd200;
    idle(300);
    leak = 8'd0;
    idle(5);
    send(7, 150, 1'b1);
    send(7, 49, 1'b1);
    idle(10);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL leak_floor_199: spikes=%0d exp=0", got_q.size()); end
    send(7, 1, 1'b1);
    idle(10);
    exp_count += 1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 6'd7) begin
      failures++; $display("FAIL leak_floor_200: n=%0d id=%0d exp n=1 id=7", got_q.size(), got_q[0]);
    end
  endtask

  task automatic check_order(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      if (bad < 0 && got_q[i] !== 6'(i)) bad = i;
    end
    checks++;
    if (got_q.size() != 64 || bad >= 0) begin
      failures++; $display("FAIL %s_order: n=%0d first_bad=%0d exp n=64 ids 0..63", name, got_q.size(), bad);
    end
    checks++;
    if (spike_count !== 32'(exp_count)) begin failures++; $display("FAIL %s_count: got=%0d exp=%0d", name, spike_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    thr = 16'd100; leak = 8'd0; refrac = 8'd0;
    clear_all();
    got_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(i, 200, 1'b1);
    idle(100);
    exp_count += 64;
    check_order("b2b");
  endtask

  task automatic test_backpressure();
    int accepted;
    int wait_n;
    logic blocked;
    clear_all();
    got_q.delete();
    m_ready = 1'b0;
    accepted = 0;
    blocked = 1'b0;
    for (int i = 0; i < 64 && !blocked; i++) begin
      s_valid = 1'b1; s_dest = 6'(i); s_weight = 8'd200; s_exc = 1'b1;
      wait_n = 0;
      @(negedge clk);
      while (!s_ready && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      if (s_ready) begin
        @(posedge clk);
        #1;
        accepted++;
      end else begin
        blocked = 1'b1;
      end
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (accepted != 25 || s_ready !== 1'b0) begin
      failures++; $display("FAIL bp_fill: accepted=%0d ready=%0b exp accepted=25 ready=0", accepted, s_ready);
    end
    checks++;
    if (got_q.size() != 0 || array_busy !== 1'b1) begin
      failures++; $display("FAIL bp_held: drained=%0d busy=%0b exp 0 and 1", got_q.size(), array_busy);
    end
    m_ready = 1'b1;
    for (int j = accepted; j < 64; j++) send(j, 200, 1'b1);
    idle(400);
    exp_count += 64;
    check_order("bp");
  endtask

  initial begin
    test_reset();
    test_below_threshold();
    test_single_fire();
    test_refractory();
    test_inhibit();
    test_saturate_and_config();
    test_leak();
    test_back_to_back();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
